key_conditioner: RTL and testbench

- Upstream front-end for the run-control FSM on the board top level.
- Takes the raw start / interrupt / reset push-keys. Synchronises each key to fpgaclock and debounces it.
- Turns each clean press into a sticky event flag. The flag holds until the slow control FSM acknowledges it, so that an FSM clocked at roughly 24 Hz never misses a press and never sees one press twice. The interrupt toggle depends on this.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce.sv | 73 +++++++
 rtl/key_conditioner.sv | 45 ++++
 tb/tb_key_conditioner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key conditioning front-end.
package key_pkg;

  // Per-key debounce FSM encoding
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } deb_state_e;

  // Key bit positions on the key buses
  localparam int KEY_START = 0;
  localparam int KEY_INTR  = 1;
  localparam int KEY_RESET = 2;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT    = 20;

endpackage

// File: rtl/key_debounce.sv
// Single-key front-end: two-flop synchroniser, debounce FSM with hold
// counter, debounced level and a one-cycle press pulse on 0->1.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic fpgaclock,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  logic [1:0]       sync_pipe;
  logic             sync2;
  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flip;

  assign sync2 = sync_pipe[1];

  // Two-flop synchroniser, plain shift with nothing between the stages
  always_ff @(posedge fpgaclock or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[0], key_raw};
  end

  // Next state: a level difference must persist until the counter reaches
  // DEBOUNCE_CYCLES; any return to the current level restarts from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flip      = 1'b0;
    case (state)
      IDLE: begin
        if (sync2 != key_level) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (sync2 == key_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          flip      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // State, counter, level and press registers; press only on a rising flip
  always_ff @(posedge fpgaclock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_level <= key_level ^ flip;
      key_press <= flip & ~key_level;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Key front-end for the run-control FSM: per-key debounce plus sticky
// event flags that survive until the slow FSM acknowledges them.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NKEYS           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             fpgaclock,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_event,
  input  logic [NKEYS-1:0] key_ack,
  output logic [NKEYS-1:0] key_overrun
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .fpgaclock (fpgaclock),
      .reset_n   (reset_n),
      .key_raw   (key_raw[i]),
      .key_level (key_level[i]),
      .key_press (key_press[i])
    );
  end

  // Sticky flags: a press beats a same-cycle ack so it is never lost;
  // overrun records a press landing on a still-unacknowledged event.
  always_ff @(posedge fpgaclock or negedge reset_n) begin
    if (!reset_n) begin
      key_event   <= '0;
      key_overrun <= '0;
    end else begin
      key_event   <= key_press | (key_event & ~key_ack);
      key_overrun <= key_overrun | (key_press & key_event & ~key_ack);
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with a short debounce window.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int DC = 4;
  localparam int CW = 3;

  logic          fpgaclock = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_raw, key_ack;
  logic [NK-1:0] key_level, key_press, key_event, key_overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            cyc;
    logic [NK-1:0] mask;
  } press_t;

  press_t exp_q[$];
  press_t obs_q[$];
  press_t obs_p;

  key_conditioner #(
    .NKEYS           (NK),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .fpgaclock   (fpgaclock),
    .reset_n     (reset_n),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_event   (key_event),
    .key_ack     (key_ack),
    .key_overrun (key_overrun)
  );

  always #5 fpgaclock = ~fpgaclock;

  always @(posedge fpgaclock) cyc <= cyc + 1;

  // Record every press pulse with the edge number that produced it
  always @(negedge fpgaclock) begin
    if (key_press !== '0) begin
      obs_p.cyc  = cyc;
      obs_p.mask = key_press;
      obs_q.push_back(obs_p);
    end
  end

  task automatic tick();
    @(posedge fpgaclock);
    #1;
  endtask

  task automatic expect_press(input int c, input logic [NK-1:0] m);
    press_t p;
    p.cyc  = c;
    p.mask = m;
    exp_q.push_back(p);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_raw = '0;
    key_ack = '0;
    #2;
    checks++;
    if ({key_level, key_press, key_event, key_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_initial: got %b want 0", {key_level, key_press, key_event, key_overrun});
    end
    key_raw = 3'b111;
    repeat (3) tick();
    checks++;
    if ({key_level, key_press, key_event, key_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b want 0", {key_level, key_press, key_event, key_overrun});
    end
    key_raw = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (DC + 4) tick();
  endtask

  task automatic test_clean_press();
    int k;
    key_raw[0] = 1'b1;
    k = cyc + 1;
    expect_press(k + DC + 2, 3'b001);
    repeat (DC + 2) tick();
    checks++;
    if (key_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_early_level: got %b want 0", key_level[0]);
    end
    tick();
    checks++;
    if (key_level[0] !== 1'b1 || key_press !== 3'b001) begin
      errors++;
      $display("FAIL clean_rise: level=%b press=%b want level=1 press=001", key_level[0], key_press);
    end
    tick();
    checks++;
    if (key_press !== 3'b000 || key_event !== 3'b001 || key_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_event: press=%b event=%b level=%b want 000/001/1", key_press, key_event, key_level[0]);
    end
  endtask

  task automatic test_bounce();
    key_raw[1] = 1'b1; tick();
    key_raw[1] = 1'b0; tick();
    key_raw[1] = 1'b1; tick();
    key_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({key_level[1], key_press[1], key_event[1]} !== 3'b000) begin
        errors++;
        $display("FAIL bounce_cycle%0d: level/press/event=%b want 000", i,
                 {key_level[1], key_press[1], key_event[1]});
      end
    end
  endtask

  task automatic test_ack();
    key_ack[0] = 1'b1;
    tick();
    key_ack[0] = 1'b0;
    checks++;
    if (key_event[0] !== 1'b0 || key_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL ack_clear: event=%b level=%b want 0/1", key_event[0], key_level[0]);
    end
    key_raw[0] = 1'b0;
    repeat (DC + 3) tick();
    checks++;
    if (key_level[0] !== 1'b0 || key_event[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_level: level=%b event=%b want 0/0", key_level[0], key_event[0]);
    end
  endtask

  task automatic test_same_cycle();
    int k;
    key_ack[2] = 1'b1;
    key_raw[2] = 1'b1;
    k = cyc + 1;
    expect_press(k + DC + 2, 3'b100);
    repeat (DC + 3) tick();
    checks++;
    if (key_press[2] !== 1'b1 || key_event[2] !== 1'b0) begin
      errors++;
      $display("FAIL samecyc_press: press=%b event=%b want 1/0", key_press[2], key_event[2]);
    end
    tick();
    checks++;
    if (key_event[2] !== 1'b1) begin
      errors++;
      $display("FAIL samecyc_set: event=%b want 1", key_event[2]);
    end
    tick();
    checks++;
    if (key_event[2] !== 1'b0 || key_overrun[2] !== 1'b0) begin
      errors++;
      $display("FAIL samecyc_clear: event=%b overrun=%b want 0/0", key_event[2], key_overrun[2]);
    end
    key_raw[2] = 1'b0;
    repeat (DC + 3) tick();
    key_ack[2] = 1'b0;
  endtask

  task automatic test_overrun();
    int k;
    for (int p = 0; p < 2; p++) begin
      key_raw[1] = 1'b1;
      k = cyc + 1;
      expect_press(k + DC + 2, 3'b010);
      repeat (20) tick();
      key_raw[1] = 1'b0;
      repeat (20) tick();
      if (p == 0) begin
        checks++;
        if (key_event[1] !== 1'b1 || key_overrun[1] !== 1'b0) begin
          errors++;
          $display("FAIL overrun_first: event=%b overrun=%b want 1/0", key_event[1], key_overrun[1]);
        end
      end
    end
    checks++;
    if (key_event[1] !== 1'b1 || key_overrun[1] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_second: event=%b overrun=%b want 1/1", key_event[1], key_overrun[1]);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    key_raw = 3'b111;
    k = cyc + 1;
    expect_press(k + DC + 2, 3'b111);
    repeat (DC + 3) tick();
    checks++;
    if (key_press !== 3'b111) begin
      errors++;
      $display("FAIL simul_press: got %b want 111", key_press);
    end
    tick();
    checks++;
    if (key_event !== 3'b111 || key_overrun !== 3'b010) begin
      errors++;
      $display("FAIL simul_event: event=%b overrun=%b want 111/010", key_event, key_overrun);
    end
    key_raw = '0;
    repeat (DC + 3) tick();
    key_ack = 3'b111;
    tick();
    key_ack = '0;
    checks++;
    if (key_event !== 3'b000 || key_level !== 3'b000) begin
      errors++;
      $display("FAIL simul_ack: event=%b level=%b want 000/000", key_event, key_level);
    end
  endtask

  task automatic test_async_reset();
    key_raw[0] = 1'b1;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    key_raw = '0;
    #1;
    checks++;
    if ({key_level, key_press, key_event, key_overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset_now: got %b want 0", {key_level, key_press, key_event, key_overrun});
    end
    repeat (2) tick();
    #2;
    reset_n = 1'b1;
    repeat (DC + 6) tick();
    checks++;
    if ({key_level, key_event, key_overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset_after: got %b want 0", {key_level, key_event, key_overrun});
    end
  endtask

  task automatic test_scoreboard();
    press_t e, o;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL press_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.mask !== e.mask) begin
        errors++;
        $display("FAIL press_match: got edge %0d mask %b want edge %0d mask %b", o.cyc, o.mask, e.cyc, e.mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ack();
    test_same_cycle();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
